gh_game_ctrl: RTL



---
 rtl/gh_pkg.sv | 18 +
 rtl/gh_game_ctrl_if.sv | 24 ++
 rtl/gh_score_accum.sv | 74 +++++++
 rtl/gh_game_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/gh_pkg.sv
// Shared types and default sizing for the Guitar Hero game-flow controller.
// The game state encoding is visible on the state output port.
package gh_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PLAY  = 2'b01,
      PAUSE = 2'b10,
      OVER  = 2'b11
   } game_state_t;

   localparam int DEF_N_LANES     = 4;
   localparam int DEF_SCORE_W     = 16;
   localparam int DEF_STREAK_W    = 8;
   localparam int DEF_STREAK_STEP = 4;
   localparam int DEF_MAX_MULT    = 4;

endpackage

// File: rtl/gh_game_ctrl_if.sv
// Game-input bundle: control requests plus per-lane button and note-window
// signals, driven by the debouncers/note scroller into the controller.
interface gh_game_ctrl_if
   import gh_pkg::*;
#(
   parameter int N_LANES = DEF_N_LANES
);

   logic               beg;
   logic               pause;
   logic               song_done;
   logic [N_LANES-1:0] hit;
   logic [N_LANES-1:0] note_win;
   logic [N_LANES-1:0] note_exp;

   modport master (
      output beg, pause, song_done, hit, note_win, note_exp
   );

   modport slave (
      input beg, pause, song_done, hit, note_win, note_exp
   );

endinterface

// File: rtl/gh_score_accum.sv
// Score, streak and multiplier registers with saturation. score_next exposes
// the candidate score so the top can capture the final score on game end.
module gh_score_accum
   import gh_pkg::*;
#(
   parameter  int N_LANES     = DEF_N_LANES,
   parameter  int SCORE_W     = DEF_SCORE_W,
   parameter  int STREAK_W    = DEF_STREAK_W,
   parameter  int STREAK_STEP = DEF_STREAK_STEP,
   parameter  int MAX_MULT    = DEF_MAX_MULT,
   localparam int G_W         = $clog2(N_LANES + 1),
   localparam int MULT_W      = $clog2(MAX_MULT + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                clear,
   input  logic [G_W-1:0]      g,
   input  logic                miss,
   output logic                point,
   output logic [SCORE_W-1:0]  score,
   output logic [SCORE_W-1:0]  score_next,
   output logic [STREAK_W-1:0] streak,
   output logic [MULT_W-1:0]   mult
);

   localparam int SUM_W = SCORE_W + G_W + MULT_W + 1;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   logic [SUM_W-1:0]    sum_wide;
   logic [STREAK_W:0]   streak_wide;
   logic [STREAK_W-1:0] streak_next;
   logic [STREAK_W-1:0] level;
   logic [MULT_W-1:0]   mult_next;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      sum_wide    = SUM_W'(score) + SUM_W'(g) * SUM_W'(mult);
      score_next  = sum_wide[SCORE_W-1:0];
      if (sum_wide > SUM_W'(SCORE_MAX))
         score_next = SCORE_MAX;

      streak_wide = (STREAK_W + 1)'(streak) + (STREAK_W + 1)'(g);
      streak_next = streak_wide[STREAK_W-1:0];
      if (miss)
         streak_next = '0;
      else if (streak_wide[STREAK_W])
         streak_next = '1;

      // Multiplier follows the streak after this cycle's update.
      level     = streak_next / STREAK_W'(STREAK_STEP);
      mult_next = MULT_W'(level) + MULT_W'(1);
      if (level >= STREAK_W'(MAX_MULT - 1))
         mult_next = MULT_W'(MAX_MULT);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         score  <= '0;
         streak <= '0;
         mult   <= MULT_W'(1);
         point  <= 1'b0;
      end else if (enable) begin
         score  <= score_next;
         streak <= streak_next;
         mult   <= mult_next;
         point  <= (g != '0);
      end else begin
         point  <= 1'b0;
      end
   end

endmodule

// File: rtl/gh_game_ctrl.sv
// Guitar Hero game-flow controller: IDLE/PLAY/PAUSE/OVER state machine,
// per-lane hit judging and session high score; scoring lives in gh_score_accum.
module gh_game_ctrl
   import gh_pkg::*;
#(
   parameter  int N_LANES     = DEF_N_LANES,
   parameter  int SCORE_W     = DEF_SCORE_W,
   parameter  int STREAK_W    = DEF_STREAK_W,
   parameter  int STREAK_STEP = DEF_STREAK_STEP,
   parameter  int MAX_MULT    = DEF_MAX_MULT,
   localparam int MULT_W      = $clog2(MAX_MULT + 1)
) (
   input  logic                clk,
   input  logic                rst,
   gh_game_ctrl_if.slave       bus,
   output logic [1:0]          state,
   output logic                point,
   output logic [SCORE_W-1:0]  score,
   output logic [STREAK_W-1:0] streak,
   output logic [MULT_W-1:0]   mult,
   output logic [SCORE_W-1:0]  high_score
);

   localparam int G_W = $clog2(N_LANES + 1);

   game_state_t        cur_state;
   game_state_t        nxt_state;
   logic               score_en;
   logic               score_clr;
   logic               hs_load;
   logic [N_LANES-1:0] good;
   logic [G_W-1:0]     g;
   logic               miss;
   logic [SCORE_W-1:0] score_next;

   always_ff @(posedge clk) begin
      if (rst)
         cur_state <= IDLE;
      else
         cur_state <= nxt_state;
   end

   always_comb begin
      nxt_state = cur_state;
      unique case (cur_state)
         IDLE:  if (bus.beg) nxt_state = PLAY;
         PLAY: begin
            if (bus.song_done)
               nxt_state = OVER;
            else if (bus.pause)
               nxt_state = PAUSE;
         end
         PAUSE: if (!bus.pause) nxt_state = PLAY;
         OVER:  if (bus.beg) nxt_state = PLAY;
         default: nxt_state = IDLE;
      endcase
   end

   // Scoring runs for every PLAY cycle, including the one leaving PLAY.
   always_comb begin
      score_en  = (cur_state == PLAY);
      score_clr = ((cur_state == IDLE) || (cur_state == OVER)) && bus.beg;
      hs_load   = (cur_state == PLAY) && bus.song_done;
   end

   always_comb begin
      good = bus.hit & bus.note_win;
      miss = (|(bus.hit & ~bus.note_win)) | (|bus.note_exp);
      g    = '0;
      for (int i = 0; i < N_LANES; i++)
         g = g + G_W'(good[i]);
   end

   gh_score_accum #(
      .N_LANES     (N_LANES),
      .SCORE_W     (SCORE_W),
      .STREAK_W    (STREAK_W),
      .STREAK_STEP (STREAK_STEP),
      .MAX_MULT    (MAX_MULT)
   ) u_accum (
      .clk        (clk),
      .rst        (rst),
      .enable     (score_en),
      .clear      (score_clr),
      .g          (g),
      .miss       (miss),
      .point      (point),
      .score      (score),
      .score_next (score_next),
      .streak     (streak),
      .mult       (mult)
   );

   // Capture the final score on the same edge the state enters OVER.
   always_ff @(posedge clk) begin
      if (rst)
         high_score <= '0;
      else if (hs_load && (score_next > high_score))
         high_score <= score_next;
   end

   assign state = cur_state;

endmodule
